// File: rtl/storage_event_scheduler.sv
// storage_event_scheduler: round-robin front end for the hit-storage write port.
// It also sequences each event boundary: drain, readout hand-off, memory clear, resume.
//
// Handshake: reqReady[i] is combinational and is high only in a cycle where
// reqValid[i] is high and requester i wins the grant. A word is transferred
// in every cycle where reqValid[i] && reqReady[i]. The requester must hold
// its word stable while reqValid is high and reqReady is low.
module storage_event_scheduler #(
  parameter int NREQ        = 4,
  parameter int SSIDBITS    = 16,
  parameter int HITINFOBITS = 8,
  parameter int DRAINCYCLES = 8,
  parameter int EVCNTBITS   = 16
) (
  input  logic                          clock,
  input  logic                          resetN,
  input  logic [NREQ-1:0]               reqValid,
  output logic [NREQ-1:0]               reqReady,
  input  logic [NREQ*SSIDBITS-1:0]      reqSSID,
  input  logic [NREQ*HITINFOBITS-1:0]   reqHitInfo,
  input  logic                          endEvent,
  input  logic                          storageReady,
  output logic                          newAddress,
  output logic [SSIDBITS-1:0]           SSID,
  output logic [HITINFOBITS-1:0]        hitInfo,
  output logic                          clearMemory,
  output logic                          readoutStart,
  input  logic                          readoutDone,
  output logic                          busy,
  output logic [EVCNTBITS-1:0]          eventCount,
  output logic                          endEventOverrun,
  output logic [2:0]                    stateDebug
);

  localparam int PTRBITS = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int DCBITS  = (DRAINCYCLES > 1) ? $clog2(DRAINCYCLES) : 1;

  typedef enum logic [2:0] {
    INITCLEAR = 3'd0,
    CLEARWAIT = 3'd1,
    ACCEPT    = 3'd2,
    DRAIN     = 3'd3,
    READOUT   = 3'd4,
    CLEAR     = 3'd5
  } stateT;

  stateT                  state;
  stateT                  stateNext;
  logic [PTRBITS-1:0]     rrPtr;
  logic [PTRBITS-1:0]     grantIdx;
  logic                   grantFound;
  logic                   grantValid;
  logic [SSIDBITS-1:0]    selSSID;
  logic [HITINFOBITS-1:0] selHitInfo;
  logic                   sawLow;
  logic                   pendingEnd;
  logic                   enterDrain;
  logic [DCBITS-1:0]      drainCount;

  assign stateDebug = state;

  // Round-robin search: first valid requester at or above the pointer, else the first one below it.
  always_comb begin
    grantFound = 1'b0;
    grantIdx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!grantFound && (i >= int'(rrPtr)) && reqValid[i]) begin
        grantFound = 1'b1;
        grantIdx   = PTRBITS'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!grantFound && (i < int'(rrPtr)) && reqValid[i]) begin
        grantFound = 1'b1;
        grantIdx   = PTRBITS'(i);
      end
    end
  end

  // Select the granted word; an end-of-event request suppresses any grant in the same cycle.
  always_comb begin
    selSSID    = '0;
    selHitInfo = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grantIdx == PTRBITS'(i)) begin
        selSSID    = reqSSID[i*SSIDBITS +: SSIDBITS];
        selHitInfo = reqHitInfo[i*HITINFOBITS +: HITINFOBITS];
      end
    end
    grantValid = (state == ACCEPT) && storageReady && !endEvent && !pendingEnd && grantFound;
    reqReady   = grantValid ? (NREQ'(1) << grantIdx) : '0;
  end

  // Next-state logic for the event sequencer.
  always_comb begin
    stateNext = state;
    case (state)
      INITCLEAR: stateNext = CLEARWAIT;
      CLEAR:     stateNext = CLEARWAIT;
      CLEARWAIT: if (sawLow && storageReady) stateNext = pendingEnd ? DRAIN : ACCEPT;
      ACCEPT:    if (endEvent || pendingEnd) stateNext = DRAIN;
      DRAIN:     if (!newAddress && (drainCount == DCBITS'(DRAINCYCLES-1))) stateNext = READOUT;
      READOUT:   if (readoutDone) stateNext = CLEAR;
      default:   stateNext = INITCLEAR;
    endcase
    enterDrain = (stateNext == DRAIN) && (state != DRAIN);
  end

  // State register, registered storage outputs and event bookkeeping.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      state           <= INITCLEAR;
      rrPtr           <= '0;
      newAddress      <= 1'b0;
      SSID            <= '0;
      hitInfo         <= '0;
      clearMemory     <= 1'b0;
      readoutStart    <= 1'b0;
      busy            <= 1'b0;
      eventCount      <= '0;
      endEventOverrun <= 1'b0;
      sawLow          <= 1'b0;
      pendingEnd      <= 1'b0;
      drainCount      <= '0;
    end else begin
      state      <= stateNext;
      newAddress <= grantValid;
      if (grantValid) begin
        SSID    <= selSSID;
        hitInfo <= selHitInfo;
        rrPtr   <= (grantIdx == PTRBITS'(NREQ-1)) ? '0 : grantIdx + PTRBITS'(1);
      end
      // Start-up clear follows the INITCLEAR cycle; the per-event clear coincides with CLEAR.
      clearMemory  <= (state == INITCLEAR) || ((stateNext == CLEAR) && (state != CLEAR));
      // Pulse lands in the final drain cycle, DRAINCYCLES cycles after the last write.
      readoutStart <= (state == DRAIN) && !newAddress && (drainCount == DCBITS'(DRAINCYCLES-2));
      busy         <= (stateNext != ACCEPT);
      if ((stateNext == CLEAR) && (state != CLEAR))
        eventCount <= eventCount + EVCNTBITS'(1);
      if ((state != DRAIN) || newAddress)
        drainCount <= '0;
      else if (drainCount != DCBITS'(DRAINCYCLES-1))
        drainCount <= drainCount + DCBITS'(1);
      // Storage must be seen to drop and recover after a clear before moving on.
      if (state == CLEARWAIT) begin
        if (!storageReady) sawLow <= 1'b1;
      end else begin
        sawLow <= 1'b0;
      end
      if (endEvent && (state != ACCEPT) && pendingEnd)
        endEventOverrun <= 1'b1;
      if (enterDrain)
        pendingEnd <= 1'b0;
      else if (endEvent && (state != ACCEPT))
        pendingEnd <= 1'b1;
    end
  end

endmodule

// File: tb/tb_storage_event_scheduler.sv
// Directed bench for storage_event_scheduler with a write-word scoreboard.
module tb_storage_event_scheduler;

  localparam int NREQ        = 4;
  localparam int SSIDBITS    = 16;
  localparam int HITINFOBITS = 8;
  localparam int DRAINCYCLES = 8;
  localparam int EVCNTBITS   = 16;
  localparam int WW          = SSIDBITS + HITINFOBITS;

  logic                        clock;
  logic                        resetN;
  logic [NREQ-1:0]             reqValid;
  logic [NREQ-1:0]             reqReady;
  logic [NREQ*SSIDBITS-1:0]    reqSSID;
  logic [NREQ*HITINFOBITS-1:0] reqHitInfo;
  logic                        endEvent;
  logic                        storageReady;
  logic                        newAddress;
  logic [SSIDBITS-1:0]         SSID;
  logic [HITINFOBITS-1:0]      hitInfo;
  logic                        clearMemory;
  logic                        readoutStart;
  logic                        readoutDone;
  logic                        busy;
  logic [EVCNTBITS-1:0]        eventCount;
  logic                        endEventOverrun;
  logic [2:0]                  stateDebug;

  logic [SSIDBITS-1:0]         wordSSID [NREQ];
  logic [HITINFOBITS-1:0]      wordHit  [NREQ];

  logic [WW-1:0] exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  logic expectWrite = 1'b0;
  logic mAccept     = 1'b0;
  int   mPtr        = 0;
  int   cnt;

  for (genvar g = 0; g < NREQ; g++) begin : gWords
    assign reqSSID[g*SSIDBITS +: SSIDBITS]          = wordSSID[g];
    assign reqHitInfo[g*HITINFOBITS +: HITINFOBITS] = wordHit[g];
  end

  storage_event_scheduler #(
    .NREQ(NREQ), .SSIDBITS(SSIDBITS), .HITINFOBITS(HITINFOBITS),
    .DRAINCYCLES(DRAINCYCLES), .EVCNTBITS(EVCNTBITS)
  ) dut (
    .clock(clock), .resetN(resetN), .reqValid(reqValid), .reqReady(reqReady),
    .reqSSID(reqSSID), .reqHitInfo(reqHitInfo), .endEvent(endEvent),
    .storageReady(storageReady), .newAddress(newAddress), .SSID(SSID),
    .hitInfo(hitInfo), .clearMemory(clearMemory), .readoutStart(readoutStart),
    .readoutDone(readoutDone), .busy(busy), .eventCount(eventCount),
    .endEventOverrun(endEventOverrun), .stateDebug(stateDebug)
  );

  // Clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic randWords();
    for (int i = 0; i < NREQ; i++) begin
      wordSSID[i] = SSIDBITS'($urandom_range(0, 65535));
      wordHit[i]  = HITINFOBITS'($urandom_range(0, 255));
    end
  endtask

  // One clock: check at the falling edge, then return just after the rising edge.
  task automatic tick();
    logic [NREQ-1:0] expReady;
    logic [WW-1:0]   expWord;
    bit              found;
    int              g;
    @(negedge clock);
    check("newAddress", 32'(newAddress), 32'(expectWrite));
    if (newAddress === 1'b1 && expectWrite) begin
      expWord = exp_q.pop_front();
      check("write_word", 32'({SSID, hitInfo}), 32'(expWord));
    end
    expectWrite = 1'b0;
    expReady    = '0;
    found       = 1'b0;
    if (mAccept && storageReady && !endEvent) begin
      for (int k = 0; k < NREQ; k++) begin
        g = (mPtr + k) % NREQ;
        if (!found && reqValid[g]) begin
          found       = 1'b1;
          expReady[g] = 1'b1;
          exp_q.push_back({wordSSID[g], wordHit[g]});
          mPtr        = (g + 1) % NREQ;
          expectWrite = 1'b1;
        end
      end
    end
    check("reqReady", 32'(reqReady), 32'(expReady));
    @(posedge clock);
    #1;
  endtask

  task automatic waitReadoutStart(input int start, output int n);
    n = start;
    while (readoutStart !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  initial begin
    resetN = 1'b0; reqValid = '0; endEvent = 1'b0; storageReady = 1'b1; readoutDone = 1'b0;
    randWords();
    @(posedge clock);
    #1;
    tick();
    tick();
    check("rst_clearMemory", 32'(clearMemory), 0);
    check("rst_readoutStart", 32'(readoutStart), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_eventCount", 32'(eventCount), 0);
    check("rst_overrun", 32'(endEventOverrun), 0);
    check("rst_SSID", 32'(SSID), 0);
    check("rst_hitInfo", 32'(hitInfo), 0);
    check("rst_state", 32'(stateDebug), 0);

    // Start-up clear; requests held but storage never dropped yet
    resetN = 1'b1; reqValid = '1;
    tick();
    check("init_clear_pulse", 32'(clearMemory), 1);
    check("init_busy", 32'(busy), 1);
    tick();
    check("init_clear_single", 32'(clearMemory), 0);
    tick();
    tick();
    check("clearwait_hold", 32'(stateDebug), 1);
    storageReady = 1'b0;
    tick();
    tick();
    check("init_no_second_clear", 32'(clearMemory), 0);
    storageReady = 1'b1;
    tick();
    mAccept = 1'b1;
    check("accept_state", 32'(stateDebug), 2);
    check("accept_busy", 32'(busy), 0);
    check("accept_eventCount", 32'(eventCount), 0);

    // Round-robin with all requesters valid
    reqValid = '1;
    for (int n = 0; n < 8; n++) begin
      randWords();
      tick();
    end
    reqValid = '0;
    tick();

    // Backpressure: pointer must not advance while storage is stalled
    storageReady = 1'b0; reqValid = 4'b0100;
    for (int n = 0; n < 3; n++) tick();
    storageReady = 1'b1;
    randWords();
    tick();
    reqValid = '1;
    randWords();
    tick();
    reqValid = '0;
    tick();

    // Event sequence: last word, then endEvent racing a request
    reqValid = 4'b0010;
    randWords();
    tick();
    reqValid = 4'b0100; endEvent = 1'b1;
    tick();
    endEvent = 1'b0; mAccept = 1'b0;
    check("drain_state", 32'(stateDebug), 3);
    check("drain_busy", 32'(busy), 1);
    readoutDone = 1'b1;
    tick();
    readoutDone = 1'b0;
    waitReadoutStart(2, cnt);
    check("drain_latency", 32'(cnt), DRAINCYCLES);
    check("readoutStart_pulse", 32'(readoutStart), 1);
    tick();
    check("readoutStart_single", 32'(readoutStart), 0);
    check("readout_state", 32'(stateDebug), 4);
    reqValid = '0;
    tick();
    tick();
    check("readout_no_clear", 32'(clearMemory), 0);
    readoutDone = 1'b1;
    tick();
    readoutDone = 1'b0;
    check("event_clear_pulse", 32'(clearMemory), 1);
    check("event_count_1", 32'(eventCount), 1);
    tick();
    check("event_clear_single", 32'(clearMemory), 0);
    storageReady = 1'b0;
    tick();
    tick();
    storageReady = 1'b1;
    tick();
    mAccept = 1'b1;
    reqValid = 4'b1000;
    randWords();
    tick();
    reqValid = '0;
    tick();

    // Pending end and overrun during readout
    endEvent = 1'b1;
    tick();
    endEvent = 1'b0; mAccept = 1'b0;
    waitReadoutStart(1, cnt);
    check("drain_length_2", 32'(cnt), DRAINCYCLES);
    tick();
    endEvent = 1'b1;
    tick();
    endEvent = 1'b0;
    tick();
    check("overrun_after_first", 32'(endEventOverrun), 0);
    endEvent = 1'b1;
    tick();
    endEvent = 1'b0;
    check("overrun_after_second", 32'(endEventOverrun), 1);
    readoutDone = 1'b1;
    tick();
    readoutDone = 1'b0;
    check("event_count_2", 32'(eventCount), 2);
    check("event_clear_pulse_2", 32'(clearMemory), 1);
    tick();
    storageReady = 1'b0;
    tick();
    storageReady = 1'b1; reqValid = '1;
    tick();
    check("pending_to_drain", 32'(stateDebug), 3);
    waitReadoutStart(1, cnt);
    check("drain_length_pending", 32'(cnt), DRAINCYCLES);
    tick();
    check("pending_readout_state", 32'(stateDebug), 4);
    check("overrun_sticky", 32'(endEventOverrun), 1);

    // Reset in the middle of readout
    resetN = 1'b0;
    tick();
    check("midrst_outputs", 32'({newAddress, clearMemory, readoutStart, busy, endEventOverrun}), 0);
    check("midrst_eventCount", 32'(eventCount), 0);
    check("midrst_word", 32'({SSID, hitInfo}), 0);
    check("midrst_reqReady", 32'(reqReady), 0);
    check("midrst_state", 32'(stateDebug), 0);
    resetN = 1'b1;
    tick();
    check("reinit_clear_pulse", 32'(clearMemory), 1);
    tick();
    check("reinit_clear_single", 32'(clearMemory), 0);
    reqValid = '0;
    tick();
    check("reinit_clear_quiet", 32'(clearMemory), 0);
    check("queue_empty", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/storage_event_scheduler.md
# storage_event_scheduler

Front-end controller for the hit-storage block: arbitrates SSID/hit-info words from NREQ upstream requesters onto the single storage write port, one word per cycle. It also sequences event boundaries: drain, hand-off to readout, memory clear, resume. It sits between the per-layer hit sources and the storage block. It is the only driver of that block's newAddress, SSID, hitInfo and clearMemory inputs.

## Interface
- NREQ, 4, number of requesters (2..8)
- SSIDBITS, from MyParameters.vh, SSID width
- HITINFOBITS, from MyParameters.vh, hit-info width
- DRAINCYCLES, 8, idle cycles after last write before the storage queues are considered empty (must be ≥ QUEUESIZE+2)
- EVCNTBITS, 16, event counter width

Ports:
- clock  in  1  single clock, all logic on posedge
- resetN  in  1  synchronous, active-low reset
- reqValid  in  NREQ  requester i has a word
- reqReady  out  NREQ  requester i word accepted this cycle
- reqSSID  in  NREQ*SSIDBITS  packed, requester i at [i*SSIDBITS +: SSIDBITS]
- reqHitInfo  in  NREQ*HITINFOBITS  packed likewise
- endEvent  in  1  single-cycle pulse, current event complete
- storageReady  in  1  from storage block
- newAddress  out  1  registered write strobe to storage
- SSID  out  SSIDBITS  registered
- hitInfo  out  HITINFOBITS  registered
- clearMemory  out  1  registered single-cycle clear pulse
- readoutStart  out  1  registered single-cycle pulse to readout block
- readoutDone  in  1  single-cycle pulse, readout finished
- busy  out  1  high in any state other than ACCEPT
- eventCount  out  EVCNTBITS  completed events, wraps modulo 2^EVCNTBITS
- endEventOverrun  out  1  sticky; set on an endEvent dropped while one is already pending

## Operation
- States: INITCLEAR, CLEARWAIT, ACCEPT, DRAIN, READOUT, CLEAR.
- Reset (resetN=0 at a clock edge):
  - state→INITCLEAR; all outputs 0; RR pointer 0; pendingEnd 0; drain counter 0.
  - Reset mid-operation abandons any event. Storage is always cleared before the first accept.
- INITCLEAR / CLEAR:
  - Assert clearMemory for exactly one cycle, then go to CLEARWAIT.
  - CLEAR additionally increments eventCount on entry.
- CLEARWAIT:
  - Wait until storageReady has been observed 0 and then 1.
  - Then go to DRAIN if pendingEnd is set, else ACCEPT.
- ACCEPT:
  - If storageReady=1, round-robin grant to the first i with reqValid[i]=1, searching from pointer upward and wrapping.
  - reqReady[i]=1 combinationally for the granted i only; at most one bit set. After a grant, pointer ← (i+1) mod NREQ.
  - If storageReady=0, all reqReady=0 and the pointer is held.
  - An accepted word appears on SSID/hitInfo with newAddress=1 on the next cycle. Otherwise newAddress=0 and SSID/hitInfo hold their last value.
  - endEvent (or pendingEnd) moves to DRAIN. No grant is issued in that cycle; an endEvent wins over a same-cycle request.
- DRAIN:
  - reqReady=0.
  - Counter resets to 0 on entry and on any cycle where newAddress=1 (the last accepted word).
  - At count = DRAINCYCLES−1: pulse readoutStart, go to READOUT.
  - pendingEnd is cleared on entry.
- READOUT:
  - reqReady=0; wait for readoutDone, then go to CLEAR.
  - No timeout.
- endEvent arriving outside ACCEPT:
  - Sets pendingEnd if clear.
  - If pendingEnd is already set, the pulse is dropped and endEventOverrun is set (cleared only by reset).
- readoutDone outside READOUT is ignored.

## Timing
- Accept-to-storage latency: 1 cycle (grant at edge N, newAddress high during cycle N+1).
- Peak throughput: one word per cycle while storageReady=1 and requests are pending.
- Fairness: with all requesters continuously valid, grants follow 0,1,2,…,NREQ−1,0,… with no gaps.
- Event turnaround from endEvent (ACCEPT, no in-flight word): DRAIN DRAINCYCLES cycles, then readoutStart, then the readout wait, then CLEAR 1 cycle, then CLEARWAIT ≥ NROWS_HNM/2 cycles.
- eventCount increments once per completed event; it wraps from all-ones to 0 without a flag.

## Test plan
- **Reset:** reset released → clearMemory pulses once, no reqReady until storageReady returns 1 after its low period; eventCount=0.
- **Round-robin:** all 4 reqValid held high, storageReady=1 for 8 cycles → grants 0,1,2,3,0,1,2,3; newAddress high on 8 consecutive cycles, each one cycle after its grant, carrying the matching SSID/hitInfo.
- **Backpressure:** storageReady=0 for 3 cycles with reqValid[2]=1 → reqReady stays 0 and the pointer is unchanged; the grant goes to 2 on the first cycle storageReady=1.
- **Event sequence:** last word accepted at cycle T, endEvent at T+1 → readoutStart exactly DRAINCYCLES cycles after the last newAddress; readoutDone → clearMemory on the next cycle; eventCount 0→1; accepts resume after storageReady recovers.
- **Pending and overrun:** two endEvent pulses during READOUT → the first is pending, the second sets endEventOverrun; after CLEARWAIT the block goes straight to DRAIN with no accepts; eventCount ends at 2.
- **Reset mid-operation:** resetN low during READOUT → all outputs 0 next cycle, then the block re-enters INITCLEAR and pulses clearMemory once.
